// File: rtl/nios2_debug_scan_host.sv
// Host-side virtual-JTAG driver for the Nios II debug slave: runs one IR/DR scan per
// accepted command, generating a divided TCK, the UIR/CDR/SDR/UDR strobes and the TDO capture.
module nios2_debug_scan_host #(
    parameter int unsigned DR_WIDTH = 38,
    parameter int unsigned IR_WIDTH = 2,
    parameter int unsigned TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr
);
    localparam int unsigned CW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam int unsigned DW = ($clog2(2 * TCK_DIV) > 0) ? $clog2(2 * TCK_DIV) : 1;
    localparam logic [DW-1:0] DMAX  = DW'(2 * TCK_DIV - 1);
    localparam logic [DW-1:0] DHALF = DW'(TCK_DIV);
    localparam logic [CW-1:0] BLAST = CW'(DR_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [DW-1:0]       r_dcnt, w_dcnt_nxt;
    logic [CW-1:0]       r_bitcnt;
    logic [DR_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [DR_WIDTH-1:0] r_cap;
    logic [DR_WIDTH-1:0] r_rsp;
    logic [IR_WIDTH-1:0] r_ir;
    logic                r_tck, r_tdi;
    logic                w_accept, w_pend, w_last;

    assign w_accept    = (r_state == S_IDLE) && cmd_valid;
    assign w_pend      = (r_dcnt == DMAX);
    assign w_last      = (r_bitcnt == BLAST);
    assign w_shift_nxt = r_shift >> 1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_state_nxt = S_UIR;
            S_UIR:   if (w_pend) w_state_nxt = S_CDR;
            S_CDR:   if (w_pend) w_state_nxt = S_SDR;
            S_SDR:   if (w_pend && w_last) w_state_nxt = S_UDR;
            S_UDR:   if (w_pend) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Phase counter wraps on each TCK falling edge; it idles at 0 in IDLE and DONE.
    always_comb begin
        w_dcnt_nxt = '0;
        if (r_state != S_IDLE && r_state != S_DONE && !w_pend)
            w_dcnt_nxt = r_dcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_dcnt   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_cap    <= '0;
            r_rsp    <= '0;
            r_ir     <= '0;
            r_tck    <= 1'b0;
            r_tdi    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_tck   <= (w_dcnt_nxt >= DHALF);
            if (w_accept) begin
                r_ir     <= cmd_ir;
                r_shift  <= cmd_dr;
                r_bitcnt <= '0;
            end
            if (r_state == S_SDR && r_dcnt == DHALF) begin
                for (int unsigned i = 0; i < DR_WIDTH; i++)
                    if (r_bitcnt == CW'(i)) r_cap[i] <= vji_tdo;
            end
            // TDI and the shift image advance only on the TCK falling edge.
            if (w_pend) begin
                case (r_state)
                    S_CDR: r_tdi <= r_shift[0];
                    S_SDR: begin
                        if (w_last) begin
                            r_tdi <= 1'b0;
                        end else begin
                            r_tdi    <= w_shift_nxt[0];
                            r_shift  <= w_shift_nxt;
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                    S_UDR:   r_rsp <= r_cap;
                    default: ;
                endcase
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign vji_rti   = (r_state == S_IDLE);
    assign vji_uir   = (r_state == S_UIR);
    assign vji_cdr   = (r_state == S_CDR);
    assign vji_sdr   = (r_state == S_SDR);
    assign vji_udr   = (r_state == S_UDR);
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_dr    = r_rsp;
    assign vji_tck   = r_tck;
    assign vji_tdi   = r_tdi;
    assign vji_ir_in = r_ir;

endmodule

// File: tb/tb_nios2_debug_scan_host.sv
// Directed bench: table of scans on a default-parameter instance plus back-to-back,
// mid-scan reset and minimum-size (TCK_DIV=1, DR_WIDTH=1) sequences.
`timescale 1ns/1ps
module tb_nios2_debug_scan_host;
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_valid, a_ready, a_rsp_valid, a_tck, a_tdi, a_tdo;
    logic        a_rti, a_uir, a_cdr, a_sdr, a_udr;
    logic [1:0]  a_ir, a_ir_in;
    logic [37:0] a_dr, a_rsp;
    int          a_mode;

    logic        b_rst_n, b_valid, b_ready, b_rsp_valid, b_tck, b_tdi, b_tdo;
    logic        b_rti, b_uir, b_cdr, b_sdr, b_udr;
    logic [1:0]  b_ir, b_ir_in;
    logic [0:0]  b_dr, b_rsp;

    // Slave models: 0 loopback, 1 inverted loopback, 2 tied low, 3 tied high.
    assign a_tdo = (a_mode == 0) ? a_tdi : (a_mode == 1) ? ~a_tdi : (a_mode == 2) ? 1'b0 : 1'b1;
    assign b_tdo = 1'b1;

    nios2_debug_scan_host #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(4)) u_a (
        .clk(clk), .reset_n(a_rst_n), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_ir(a_ir), .cmd_dr(a_dr), .rsp_valid(a_rsp_valid), .rsp_dr(a_rsp),
        .vji_tck(a_tck), .vji_tdi(a_tdi), .vji_tdo(a_tdo), .vji_ir_in(a_ir_in),
        .vji_rti(a_rti), .vji_uir(a_uir), .vji_cdr(a_cdr), .vji_sdr(a_sdr), .vji_udr(a_udr)
    );

    nios2_debug_scan_host #(.DR_WIDTH(1), .IR_WIDTH(2), .TCK_DIV(1)) u_b (
        .clk(clk), .reset_n(b_rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_ir(b_ir), .cmd_dr(b_dr), .rsp_valid(b_rsp_valid), .rsp_dr(b_rsp),
        .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(b_tdo), .vji_ir_in(b_ir_in),
        .vji_rti(b_rti), .vji_uir(b_uir), .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr)
    );

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] dr;
        int          mode;
        logic [37:0] exp;
    } vec_t;

    vec_t tbl [5];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full scan on u_a, with cycle 0 being the clk whose rising edge accepts the command.
    task automatic scan_a(input logic [1:0] ir, input logic [37:0] dr, input int mode,
                          input logic [37:0] exp, input string tag);
        int vcnt = 0, vcyc = -1, rises = 0, first_rise = -1;
        int b_uir = 0, b_cdr = 0, b_sdr = 0, b_udr = 0, b_tdi = 0, b_ir = 0, b_rdy = 0;
        logic prev_tck, exp_tdi;
        logic [37:0] rsp = '0;
        @(negedge clk);
        a_mode  = mode;
        a_ir    = ir;
        a_dr    = dr;
        a_valid = 1'b1;
        chk({tag, " ready_before"}, 64'(a_ready), 64'(1));
        prev_tck = a_tck;
        for (int k = 1; k <= 340; k++) begin
            @(negedge clk);
            if (k == 1) a_valid = 1'b0;
            if (a_uir !== (k >= 1 && k <= 8))     b_uir++;
            if (a_cdr !== (k >= 9 && k <= 16))    b_cdr++;
            if (a_sdr !== (k >= 17 && k <= 320))  b_sdr++;
            if (a_udr !== (k >= 321 && k <= 328)) b_udr++;
            exp_tdi = (k >= 17 && k <= 320) ? dr[(k - 17) / 8] : 1'b0;
            if (a_tdi !== exp_tdi) b_tdi++;
            if (a_ir_in !== ir) b_ir++;
            if (a_ready !== (k >= 330) || a_rti !== (k >= 330)) b_rdy++;
            if (a_tck && !prev_tck) begin
                rises++;
                if (first_rise < 0) first_rise = k;
            end
            prev_tck = a_tck;
            if (a_rsp_valid) begin
                vcnt++;
                vcyc = k;
                rsp  = a_rsp;
            end
        end
        chk({tag, " rsp_valid_count"}, 64'(vcnt), 64'(1));
        chk({tag, " rsp_valid_cycle"}, 64'(vcyc), 64'(329));
        chk({tag, " rsp_dr"}, 64'(rsp), 64'(exp));
        chk({tag, " rsp_dr_hold"}, 64'(a_rsp), 64'(exp));
        chk({tag, " uir_bad_cycles"}, 64'(b_uir), 64'(0));
        chk({tag, " cdr_bad_cycles"}, 64'(b_cdr), 64'(0));
        chk({tag, " sdr_bad_cycles"}, 64'(b_sdr), 64'(0));
        chk({tag, " udr_bad_cycles"}, 64'(b_udr), 64'(0));
        chk({tag, " tdi_bad_cycles"}, 64'(b_tdi), 64'(0));
        chk({tag, " ir_in_bad_cycles"}, 64'(b_ir), 64'(0));
        chk({tag, " ready_rti_bad_cycles"}, 64'(b_rdy), 64'(0));
        chk({tag, " tck_rises"}, 64'(rises), 64'(41));
        chk({tag, " tck_first_rise"}, 64'(first_rise), 64'(5));
    endtask

    initial begin
        int bad, acc, first_acc, second_acc, first_v, vc, bvc, bvcyc;
        logic [0:0] brsp;

        tbl[0] = '{2'b10, 38'h2A_5555_AAAA, 0, 38'h2A_5555_AAAA};
        tbl[1] = '{2'b01, 38'h3F_FFFF_FFFF, 0, 38'h3F_FFFF_FFFF};
        tbl[2] = '{2'b11, 38'h00_0000_0001, 1, 38'h3F_FFFF_FFFE};
        tbl[3] = '{2'b00, 38'h12_3456_789A, 2, 38'h00_0000_0000};
        tbl[4] = '{2'b01, 38'h00_0000_0000, 3, 38'h3F_FFFF_FFFF};

        a_rst_n = 1'b0; a_valid = 1'b0; a_ir = '0; a_dr = '0; a_mode = 0;
        b_rst_n = 1'b0; b_valid = 1'b0; b_ir = '0; b_dr = '0;
        repeat (3) @(negedge clk);
        chk("reset cmd_ready", 64'(a_ready), 64'(1));
        chk("reset vji_rti", 64'(a_rti), 64'(1));
        chk("reset outputs_zero",
            64'({a_tck, a_tdi, a_uir, a_cdr, a_sdr, a_udr, a_rsp_valid, a_ir_in, a_rsp}), 64'(0));
        chk("reset b_outputs", 64'({b_ready, b_rti, b_tck, b_uir, b_sdr, b_rsp_valid, b_rsp}),
            64'(7'b1100000));
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (a_tck !== 1'b0 || {a_uir, a_cdr, a_sdr, a_udr} !== 4'b0 ||
                a_ready !== 1'b1 || a_rti !== 1'b1) bad++;
        end
        chk("idle_100clk bad_cycles", 64'(bad), 64'(0));

        for (int v = 0; v < 5; v++)
            scan_a(tbl[v].ir, tbl[v].dr, tbl[v].mode, tbl[v].exp, $sformatf("vec%0d", v));

        // Back-to-back: cmd_valid held high across two complete scans.
        @(negedge clk);
        a_mode = 0; a_ir = 2'b01; a_dr = 38'h2A_5555_AAAA; a_valid = 1'b1;
        acc = 0; first_acc = -1; second_acc = -1; first_v = -1; vc = 0;
        for (int k = 0; k < 660; k++) begin
            if (k > 0) @(negedge clk);
            if (a_rsp_valid) begin
                vc++;
                if (first_v < 0) first_v = k;
            end
            if (a_ready) begin
                acc++;
                if (acc == 1) first_acc = k;
                else if (acc == 2) second_acc = k;
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
        chk("b2b accept_count", 64'(acc), 64'(2));
        chk("b2b first_accept", 64'(first_acc), 64'(0));
        chk("b2b first_rsp_valid", 64'(first_v), 64'(329));
        chk("b2b second_accept", 64'(second_acc), 64'(330));
        chk("b2b rsp_valid_count", 64'(vc), 64'(2));
        repeat (5) @(negedge clk);

        // Reset pulsed asynchronously in the middle of SDR bit 20.
        @(negedge clk);
        a_mode = 0; a_ir = 2'b11; a_dr = 38'h15_0F0F_F0F0; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (179) @(negedge clk);
        chk("midrst sdr_before", 64'(a_sdr), 64'(1));
        a_rst_n = 1'b0;
        #1;
        chk("midrst ready_rti", 64'({a_ready, a_rti}), 64'(2'b11));
        chk("midrst strobes_tck_tdi", 64'({a_uir, a_cdr, a_sdr, a_udr, a_tck, a_tdi}), 64'(0));
        chk("midrst ir_in", 64'(a_ir_in), 64'(0));
        chk("midrst rsp_dr", 64'(a_rsp), 64'(0));
        chk("midrst rsp_valid", 64'(a_rsp_valid), 64'(0));
        @(negedge clk);
        @(negedge clk);
        a_rst_n = 1'b1;
        bad = 0;
        repeat (400) begin
            @(negedge clk);
            if (a_rsp_valid !== 1'b0 || a_ready !== 1'b1) bad++;
        end
        chk("midrst no_rsp_after", 64'(bad), 64'(0));
        scan_a(2'b10, 38'h0F_1234_5678, 0, 38'h0F_1234_5678, "post_rst");

        // Minimum configuration with TDO tied high.
        @(negedge clk);
        b_ir = 2'b01; b_dr = 1'b0; b_valid = 1'b1;
        bvc = 0; bvcyc = -1; brsp = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) b_valid = 1'b0;
            if (b_rsp_valid) begin
                bvc++;
                bvcyc = k;
                brsp  = b_rsp;
            end
        end
        chk("min rsp_valid_cycle", 64'(bvcyc), 64'(9));
        chk("min rsp_valid_count", 64'(bvc), 64'(1));
        chk("min rsp_dr", 64'(brsp), 64'(1));
        chk("min ir_in", 64'(b_ir_in), 64'(2'b01));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
